// File: rtl/axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// axi_bridge_pkg
//   Shared definitions for the synchronous AXI4 bridge.
//   - AXI burst and response encodings.
//   - Fixed AXI field widths.
//   - Payload-width functions for the AW/AR, W, B and R FIFOs.
//   - clog2 helper, usable in parameter and localparam expressions.
// -----------------------------------------------------------------------------
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  // Ceiling log2.
  // clog2(1) = 0 and clog2(2) = 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Address-channel payload: {ID, ADDR, LEN, SIZE, BURST}.
  function automatic int ax_payload_width(input int id_w, input int ad_w);
    return id_w + ad_w + LEN_W + SIZE_W + BURST_W;
  endfunction

  // Write-data payload: {DATA, STRB, LAST}.
  function automatic int w_payload_width(input int da_w);
    return da_w + (da_w / 8) + 1;
  endfunction

  // Write-response payload: {ID, RESP}.
  function automatic int b_payload_width(input int id_w);
    return id_w + RESP_W;
  endfunction

  // Read-data payload: {ID, DATA, RESP, LAST}.
  function automatic int r_payload_width(input int id_w, input int da_w);
    return id_w + da_w + RESP_W + 1;
  endfunction

endpackage

// File: rtl/axi_bridge_fifo_sync.sv
// -----------------------------------------------------------------------------
// axi_bridge_fifo_sync
//   Single-clock FIFO with a valid/ready handshake on both sides.
//   - push_ready comes only from the registered fill count.
//     When the FIFO is full and popped in the same cycle, the push is refused.
//   - pop_valid is high whenever the FIFO holds at least one entry.
//     pop_data is the head entry.
//   - Both handshake outputs are forced low while rst is high.
//
//   Parameters:
//     WIDTH  payload width
//     DEPTH  number of entries; a power of two, >= 2
//
//   Ports:
//     clk         clock, rising edge
//     rst         synchronous active-high reset; clears pointers and count
//     push_valid  source side: beat offered
//     push_ready  source side: FIFO can accept a beat
//     push_data   source side: payload
//     pop_valid   sink side: head entry available
//     pop_ready   sink side: head entry consumed
//     pop_data    sink side: head payload
// -----------------------------------------------------------------------------
module axi_bridge_fifo_sync
  import axi_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int                PTR_W    = clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign push_ready = (count != FULL_CNT) && !rst;
  assign pop_valid  = (count != '0) && !rst;
  assign pop_data   = mem[rd_ptr];

  assign do_push = push_valid && push_ready;
  assign do_pop  = pop_valid && pop_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: Sequential state uses non-blocking assignments.
  //       This ensures every register in the block samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: The storage array is intentionally not reset.
  //       Stale entries are unreachable once count is cleared.
  //       Leaving the array unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_bridge_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// axi_bridge_sync_fifo_param
//   Single-clock AXI4 bridge. Each of the five channels runs through its own
//   axi_bridge_fifo_sync, so every S-side output is driven from registered state.
//   Payloads pass through unmodified, and order is kept per channel.
//
//   Optional feature, enabled by defining AXI_BRIDGE_OUTSTANDING_LIMIT_EN:
//     - wr_cnt gates S_AWREADY against MAX_WR.
//       It counts AW handshakes up and B handshakes down.
//     - rd_cnt gates S_ARREADY against MAX_RD.
//       It counts AR handshakes up and last-beat R handshakes down.
//     - When the macro is undefined, MAX_WR and MAX_RD have no effect.
//
//   Ports:
//     ACLK, ARESET  clock and synchronous active-high reset
//     S_AW*, S_W*, S_AR*  upstream request channels (inputs, READY out)
//     S_B*, S_R*          upstream response channels (outputs, READY in)
//     M_AW*, M_W*, M_AR*  downstream request channels (outputs, READY in)
//     M_B*, M_R*          downstream response channels (inputs, READY out)
// -----------------------------------------------------------------------------
module axi_bridge_sync_fifo_param
  import axi_bridge_pkg::*;
#(
  parameter int AXI_WIDTH_ID = 8,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int DEPTH_AW     = 2,
  parameter int DEPTH_W      = 4,
  parameter int DEPTH_B      = 2,
  parameter int DEPTH_AR     = 2,
  parameter int DEPTH_R      = 4,
  parameter int MAX_WR       = 8,
  parameter int MAX_RD       = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // Slave-side write address
  input  logic [AXI_WIDTH_ID-1:0]   S_AWID,
  input  logic [AXI_WIDTH_AD-1:0]   S_AWADDR,
  input  logic [7:0]                S_AWLEN,
  input  logic [2:0]                S_AWSIZE,
  input  logic [1:0]                S_AWBURST,
  input  logic                      S_AWVALID,
  output logic                      S_AWREADY,
  // Slave-side write data
  input  logic [AXI_WIDTH_DA-1:0]   S_WDATA,
  input  logic [AXI_WIDTH_DA/8-1:0] S_WSTRB,
  input  logic                      S_WLAST,
  input  logic                      S_WVALID,
  output logic                      S_WREADY,
  // Slave-side write response
  output logic [AXI_WIDTH_ID-1:0]   S_BID,
  output logic [1:0]                S_BRESP,
  output logic                      S_BVALID,
  input  logic                      S_BREADY,
  // Slave-side read address
  input  logic [AXI_WIDTH_ID-1:0]   S_ARID,
  input  logic [AXI_WIDTH_AD-1:0]   S_ARADDR,
  input  logic [7:0]                S_ARLEN,
  input  logic [2:0]                S_ARSIZE,
  input  logic [1:0]                S_ARBURST,
  input  logic                      S_ARVALID,
  output logic                      S_ARREADY,
  // Slave-side read data
  output logic [AXI_WIDTH_ID-1:0]   S_RID,
  output logic [AXI_WIDTH_DA-1:0]   S_RDATA,
  output logic [1:0]                S_RRESP,
  output logic                      S_RLAST,
  output logic                      S_RVALID,
  input  logic                      S_RREADY,
  // Master-side write address
  output logic [AXI_WIDTH_ID-1:0]   M_AWID,
  output logic [AXI_WIDTH_AD-1:0]   M_AWADDR,
  output logic [7:0]                M_AWLEN,
  output logic [2:0]                M_AWSIZE,
  output logic [1:0]                M_AWBURST,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  // Master-side write data
  output logic [AXI_WIDTH_DA-1:0]   M_WDATA,
  output logic [AXI_WIDTH_DA/8-1:0] M_WSTRB,
  output logic                      M_WLAST,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  // Master-side write response
  input  logic [AXI_WIDTH_ID-1:0]   M_BID,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  // Master-side read address
  output logic [AXI_WIDTH_ID-1:0]   M_ARID,
  output logic [AXI_WIDTH_AD-1:0]   M_ARADDR,
  output logic [7:0]                M_ARLEN,
  output logic [2:0]                M_ARSIZE,
  output logic [1:0]                M_ARBURST,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  // Master-side read data
  input  logic [AXI_WIDTH_ID-1:0]   M_RID,
  input  logic [AXI_WIDTH_DA-1:0]   M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RLAST,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  localparam int AX_W = ax_payload_width(AXI_WIDTH_ID, AXI_WIDTH_AD);
  localparam int W_W  = w_payload_width(AXI_WIDTH_DA);
  localparam int B_W  = b_payload_width(AXI_WIDTH_ID);
  localparam int R_W  = r_payload_width(AXI_WIDTH_ID, AXI_WIDTH_DA);

  logic [AX_W-1:0] aw_out;
  logic [W_W-1:0]  w_out;
  logic [B_W-1:0]  b_out;
  logic [AX_W-1:0] ar_out;
  logic [R_W-1:0]  r_out;

  logic aw_fifo_ready;
  logic ar_fifo_ready;
  logic wr_ok;
  logic rd_ok;

  // The limiter gates both READY and the FIFO push together.
  // This keeps the counters and the FIFO contents in step.
  assign S_AWREADY = aw_fifo_ready && wr_ok;
  assign S_ARREADY = ar_fifo_ready && rd_ok;

`ifdef AXI_BRIDGE_OUTSTANDING_LIMIT_EN
  localparam int                    WR_CNT_W = clog2(MAX_WR + 1);
  localparam int                    RD_CNT_W = clog2(MAX_RD + 1);
  localparam logic [WR_CNT_W-1:0]   WR_LIMIT = WR_CNT_W'(MAX_WR);
  localparam logic [RD_CNT_W-1:0]   RD_LIMIT = RD_CNT_W'(MAX_RD);

  logic [WR_CNT_W-1:0] wr_cnt;
  logic [RD_CNT_W-1:0] rd_cnt;
  logic                wr_inc;
  logic                wr_dec;
  logic                rd_inc;
  logic                rd_dec;

  assign wr_ok  = wr_cnt < WR_LIMIT;
  assign rd_ok  = rd_cnt < RD_LIMIT;
  assign wr_inc = S_AWVALID && S_AWREADY;
  assign wr_dec = S_BVALID && S_BREADY;
  assign rd_inc = S_ARVALID && S_ARREADY;
  // A read transaction retires on its last data beat.
  assign rd_dec = S_RVALID && S_RREADY && S_RLAST;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      unique case ({wr_inc, wr_dec})
        2'b10:   wr_cnt <= wr_cnt + WR_CNT_W'(1);
        2'b01:   wr_cnt <= wr_cnt - WR_CNT_W'(1);
        default: wr_cnt <= wr_cnt;
      endcase
      unique case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + RD_CNT_W'(1);
        2'b01:   rd_cnt <= rd_cnt - RD_CNT_W'(1);
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  // Write address: S -> M
  axi_bridge_fifo_sync #(.WIDTH(AX_W), .DEPTH(DEPTH_AW)) u_aw_fifo (
    .clk        (ACLK),
    .rst        (ARESET),
    .push_valid (S_AWVALID && wr_ok),
    .push_ready (aw_fifo_ready),
    .push_data  ({S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST}),
    .pop_valid  (M_AWVALID),
    .pop_ready  (M_AWREADY),
    .pop_data   (aw_out)
  );
  assign {M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST} = aw_out;

  // Write data: S -> M
  axi_bridge_fifo_sync #(.WIDTH(W_W), .DEPTH(DEPTH_W)) u_w_fifo (
    .clk        (ACLK),
    .rst        (ARESET),
    .push_valid (S_WVALID),
    .push_ready (S_WREADY),
    .push_data  ({S_WDATA, S_WSTRB, S_WLAST}),
    .pop_valid  (M_WVALID),
    .pop_ready  (M_WREADY),
    .pop_data   (w_out)
  );
  assign {M_WDATA, M_WSTRB, M_WLAST} = w_out;

  // Write response: M -> S
  axi_bridge_fifo_sync #(.WIDTH(B_W), .DEPTH(DEPTH_B)) u_b_fifo (
    .clk        (ACLK),
    .rst        (ARESET),
    .push_valid (M_BVALID),
    .push_ready (M_BREADY),
    .push_data  ({M_BID, M_BRESP}),
    .pop_valid  (S_BVALID),
    .pop_ready  (S_BREADY),
    .pop_data   (b_out)
  );
  assign {S_BID, S_BRESP} = b_out;

  // Read address: S -> M
  axi_bridge_fifo_sync #(.WIDTH(AX_W), .DEPTH(DEPTH_AR)) u_ar_fifo (
    .clk        (ACLK),
    .rst        (ARESET),
    .push_valid (S_ARVALID && rd_ok),
    .push_ready (ar_fifo_ready),
    .push_data  ({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST}),
    .pop_valid  (M_ARVALID),
    .pop_ready  (M_ARREADY),
    .pop_data   (ar_out)
  );
  assign {M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST} = ar_out;

  // Read data: M -> S
  axi_bridge_fifo_sync #(.WIDTH(R_W), .DEPTH(DEPTH_R)) u_r_fifo (
    .clk        (ACLK),
    .rst        (ARESET),
    .push_valid (M_RVALID),
    .push_ready (M_RREADY),
    .push_data  ({M_RID, M_RDATA, M_RRESP, M_RLAST}),
    .pop_valid  (S_RVALID),
    .pop_ready  (S_RREADY),
    .pop_data   (r_out)
  );
  assign {S_RID, S_RDATA, S_RRESP, S_RLAST} = r_out;

endmodule
